// File: rtl/pred_pkg.sv
// Shared types and helpers for the predictor shift tuner.
package pred_pkg;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_e;

    function automatic int unsigned bits_for(input int unsigned maxval);
        return $clog2(maxval + 1);
    endfunction

    function automatic int unsigned acc_bits(input int unsigned cw, input int unsigned avg_log2);
        return cw + avg_log2;
    endfunction

    // The predictor loads shift-1, so the result never goes below 1.
    function automatic int clamp_shift(input int diff, input int unsigned pmax);
        if (diff <= 0)
            return 1;
        else if (diff > int'(pmax))
            return int'(pmax);
        return diff;
    endfunction

endpackage

// File: rtl/pred_tune_avg.sv
// Block accumulator, averaging divide and clamped two-stage output pipeline.
module pred_tune_avg
    import pred_pkg::*;
#(
    parameter int unsigned PRED_PARAMETER = 255,
    parameter int unsigned PERIOD_MAX     = 1023,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned SHIFT_INIT     = 1,
    localparam int unsigned W             = bits_for(PRED_PARAMETER),
    localparam int unsigned CW            = bits_for(PERIOD_MAX),
    localparam int unsigned AW            = acc_bits(CW, AVG_LOG2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          smp_vld_i,
    input  logic [CW-1:0] smp_i,
    input  logic [W-1:0]  lead_i,
    output logic [W-1:0]  shift_o,
    output logic          lock_o,
    output logic          upd_o,
    output logic [CW-1:0] half_period_o
);

    logic [AW-1:0]       acc_q, acc_d;
    logic [AVG_LOG2-1:0] idx_q, idx_d;
    logic [CW-1:0]       avg_q, avg_d;
    logic                v1_q, v1_d;
    logic [W-1:0]        shift_q, shift_d;
    logic                lock_q, lock_d;
    logic                upd_q, upd_d;
    logic [CW-1:0]       hp_q, hp_d;
    logic [AW-1:0]       sum;
    logic signed [CW:0]  diff;

    always_comb begin
        acc_d   = acc_q;
        idx_d   = idx_q;
        avg_d   = avg_q;
        v1_d    = 1'b0;
        shift_d = shift_q;
        lock_d  = lock_q;
        upd_d   = 1'b0;
        hp_d    = hp_q;
        sum     = acc_q + AW'(smp_i);
        diff    = $signed({1'b0, avg_q}) - $signed({{(CW + 1 - W){1'b0}}, lead_i});

        // An abort landing on the second pipeline stage also suppresses that result.
        if (v1_q && !clr_i) begin
            hp_d    = avg_q;
            shift_d = W'(clamp_shift(int'(diff), PRED_PARAMETER));
            lock_d  = 1'b1;
            upd_d   = 1'b1;
        end

        if (clr_i) begin
            acc_d  = '0;
            idx_d  = '0;
            lock_d = 1'b0;
        end else if (smp_vld_i) begin
            if (&idx_q) begin
                avg_d = sum[AW-1:AVG_LOG2];
                v1_d  = 1'b1;
                acc_d = '0;
                idx_d = '0;
            end else begin
                acc_d = sum;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            idx_q   <= '0;
            avg_q   <= '0;
            v1_q    <= 1'b0;
            shift_q <= W'(SHIFT_INIT);
            lock_q  <= 1'b0;
            upd_q   <= 1'b0;
            hp_q    <= '0;
        end else begin
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            avg_q   <= avg_d;
            v1_q    <= v1_d;
            shift_q <= shift_d;
            lock_q  <= lock_d;
            upd_q   <= upd_d;
            hp_q    <= hp_d;
        end
    end

    assign shift_o       = shift_q;
    assign lock_o        = lock_q;
    assign upd_o         = upd_q;
    assign half_period_o = hp_q;

endmodule

// File: rtl/sync.sv
// Multi-bit two-flop synchronizer for asynchronous inputs.
module sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pred_tune.sv
// Closed-loop tuner: measures feedback half-period and derives the predictor shift.
module pred_tune
    import pred_pkg::*;
#(
    parameter int unsigned PRED_PARAMETER = 255,
    parameter int unsigned PERIOD_MAX     = 1023,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned MIN_HALF       = 4,
    parameter int unsigned SHIFT_INIT     = 1,
    localparam int unsigned W             = bits_for(PRED_PARAMETER),
    localparam int unsigned CW            = bits_for(PERIOD_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sgn,
    input  logic          en,
    input  logic [W-1:0]  lead,
    output logic [W-1:0]  shift,
    output logic          lock,
    output logic          upd,
    output logic [CW-1:0] half_period
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sgn_s;
    logic          sgn_d_q;
    logic          edg;
    logic          smp_vld;
    logic          clr;

    sync #(.WIDTH(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (sgn),
        .q_o (sgn_s)
    );

    assign edg = sgn_s ^ sgn_d_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        smp_vld = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && edg) begin
                    state_d = MEASURE;
                    cnt_d   = CW'(1);
                    clr     = 1'b1;
                end
            end
            MEASURE: begin
                if (!en) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end else if (edg) begin
                    // Edge outranks timeout: a saturated count is still a valid sample.
                    cnt_d = CW'(1);
                    if (cnt_q < CW'(MIN_HALF)) begin
                        state_d = IDLE;
                        clr     = 1'b1;
                    end else begin
                        smp_vld = 1'b1;
                    end
                end else if (cnt_q == CW'(PERIOD_MAX)) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sgn_d_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_d_q <= sgn_s;
        end
    end

    pred_tune_avg #(
        .PRED_PARAMETER (PRED_PARAMETER),
        .PERIOD_MAX     (PERIOD_MAX),
        .AVG_LOG2       (AVG_LOG2),
        .SHIFT_INIT     (SHIFT_INIT)
    ) u_avg (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (clr),
        .smp_vld_i     (smp_vld),
        .smp_i         (cnt_q),
        .lead_i        (lead),
        .shift_o       (shift),
        .lock_o        (lock),
        .upd_o         (upd),
        .half_period_o (half_period)
    );

endmodule

// File: tb/tb_pred_tune.sv
// Scoreboard bench for pred_tune: stimulus pushes expected updates, monitor pops on upd.
module tb_pred_tune;

    logic       clk = 1'b0;
    logic       rst;
    logic       sgn;
    logic       en;
    logic [7:0] lead;
    logic [7:0] shift;
    logic       lock;
    logic       upd;
    logic [9:0] half_period;

    typedef struct {
        int hp;
        int sh;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic upd_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pred_tune #(
        .PRED_PARAMETER (255),
        .PERIOD_MAX     (1023),
        .AVG_LOG2       (2),
        .MIN_HALF       (4),
        .SHIFT_INIT     (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sgn         (sgn),
        .en          (en),
        .lead        (lead),
        .shift       (shift),
        .lock        (lock),
        .upd         (upd),
        .half_period (half_period)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && upd) begin
            chk("upd_width", int'(upd_prev), 0);
            if (sb.size() == 0) begin
                chk("unexpected_upd", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("half_period", int'(half_period), e.hp);
                chk("shift", int'(shift), e.sh);
                chk("lock_at_upd", int'(lock), 1);
                chk("upd_cycle", cyc, e.cyc);
            end
        end
        upd_prev = upd;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic half(input int h);
        tick(h);
        sgn = ~sgn;
    endtask

    // Four half-periods closing a block; upd is due 4 cycles after the closing toggle.
    task automatic block(input int h0, input int h1, input int h2, input int h3,
                         input int hp, input int sh);
        exp_t e;
        half(h0);
        half(h1);
        half(h2);
        half(h3);
        e.hp  = hp;
        e.sh  = sh;
        e.cyc = cyc + 4;
        sb.push_back(e);
    endtask

    initial begin
        rst  = 1'b1;
        sgn  = 1'b0;
        en   = 1'b1;
        lead = 8'd20;

        // Reset with sgn toggling
        repeat (3) begin
            @(negedge clk);
            chk("rst_shift", int'(shift), 1);
            chk("rst_lock", int'(lock), 0);
            chk("rst_upd", int'(upd), 0);
            chk("rst_hp", int'(half_period), 0);
            sgn = ~sgn;
        end
        @(negedge clk);
        sgn = 1'b0;
        rst = 1'b0;
        tick(10);
        chk("post_rst_lock", int'(lock), 0);
        chk("post_rst_shift", int'(shift), 1);

        // First lock: half-period 100, lead 20
        sgn = ~sgn;
        block(100, 100, 100, 100, 100, 80);
        chk("prelock_lock", int'(lock), 0);
        chk("prelock_hp", int'(half_period), 0);
        chk("prelock_shift", int'(shift), 1);
        block(100, 100, 100, 100, 100, 80);
        tick(10);
        chk("locked", int'(lock), 1);

        // Clamp low and high
        lead = 8'd120;
        block(90, 100, 100, 100, 100, 1);
        tick(10);
        lead = 8'd10;
        block(390, 400, 400, 400, 400, 255);
        tick(10);
        lead = 8'd20;
        block(90, 100, 100, 100, 100, 80);

        // Timeout: last edge driven now, count saturates 1025 cycles later
        tick(1025);
        chk("pre_timeout_lock", int'(lock), 1);
        tick(1);
        chk("timeout_lock", int'(lock), 0);
        chk("timeout_shift", int'(shift), 80);
        chk("timeout_hp", int'(half_period), 100);
        tick(74);
        sgn = ~sgn;
        block(100, 100, 100, 100, 100, 80);

        // Glitch pulse mid half-period
        tick(50);
        sgn = ~sgn;
        tick(2);
        sgn = ~sgn;
        tick(5);
        chk("glitch_lock", int'(lock), 0);
        chk("glitch_shift", int'(shift), 80);
        chk("glitch_hp", int'(half_period), 100);
        tick(100);
        sgn = ~sgn;
        block(100, 100, 100, 100, 100, 80);

        // Alternating half-periods average out
        block(99, 101, 99, 101, 100, 80);

        // Drop en mid-block; partial samples must be discarded
        half(100);
        half(100);
        tick(10);
        en = 1'b0;
        tick(2);
        chk("en_drop_lock", int'(lock), 0);
        chk("en_drop_shift", int'(shift), 80);
        sgn = ~sgn;
        tick(20);
        en = 1'b1;
        tick(50);
        sgn = ~sgn;
        block(120, 120, 120, 120, 120, 100);

        // MIN_HALF boundary, then truncating average with small lead
        block(4, 4, 4, 4, 4, 1);
        tick(6);
        lead = 8'd2;
        block(5, 5, 5, 5, 6, 4);

        tick(20);
        chk("pending_upd", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pred_tune.md
Name: pred_tune

Overview:
- Closed-loop tuner that produces the `shift` value consumed by the edge predictor.
- Measures the half-period of the resonant-current feedback signal and averages it over a block of half-periods.
- Outputs shift = average half-period minus a programmed lead time, saturated to the predictor's range.
- Sits between the feedback comparator input and the predictor's `shift` port, in the same clk domain.

Parameters:
- PRED_PARAMETER, 255: maximum shift value; W = $clog2(PRED_PARAMETER+1) is the width of shift and lead.
- PERIOD_MAX, 1023: half-period counter ceiling and timeout; CW = $clog2(PERIOD_MAX+1).
- AVG_LOG2, 2: log2 of the number of half-periods averaged per block (N = 4).
- MIN_HALF, 4: shortest legal half-period in clk cycles; shorter samples are glitches.
- SHIFT_INIT, 1: shift value after reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sgn  input  1  asynchronous feedback square wave.
- en  input  1  tuning enable.
- lead  input  W  desired phase lead in clk cycles.
- shift  output  W  predictor shift value.
- lock  output  1  high while shift reflects a valid, current measurement.
- upd  output  1  one-cycle pulse when shift or half_period is updated.
- half_period  output  CW  last block-averaged half-period.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). On rst: shift=SHIFT_INIT, lock=0, upd=0, half_period=0, state=IDLE, counter, accumulator and index cleared. Reset mid-block discards all partial data.
- Input path: sgn passes through the 2-flop sync (WIDTH 1), then one delay register. An edge is a cycle where sgn_s != sgn_d (either polarity).
- States:
  - IDLE: counter frozen. Edge with en=1 -> MEASURE, cnt=1, acc=0, idx=0.
  - MEASURE: cnt increments each cycle, saturating at PERIOD_MAX.
    - On edge: sample = cnt, then cnt reloads to 1.
    - sample < MIN_HALF: glitch -> IDLE, acc/idx cleared, lock=0; shift and half_period hold.
    - Otherwise acc += sample and idx++.
    - When idx == N-1 on a valid edge: block complete, acc/idx cleared, stay in MEASURE.
    - Timeout: cnt == PERIOD_MAX with no edge -> IDLE, lock=0, acc/idx cleared, shift held. An edge in that same cycle is a valid sample of PERIOD_MAX; the edge wins.
- en=0 in any state: next cycle -> IDLE, lock=0, acc cleared, shift held, no upd.
- Compute pipeline, from the block-completing edge cycle E:
  - E+1: avg = (acc + sample) >> AVG_LOG2, CW bits, truncating.
  - E+2: half_period=avg; shift=clamp(avg - lead) (rule below); lock=1; upd=1 for exactly one cycle.
  - lead is sampled at E+1.
- Arithmetic: the subtraction is signed, CW+1 bits.
  - Result <= 0 -> shift=1. shift is never 0, because the predictor loads shift-1.
  - Result > PRED_PARAMETER -> shift=PRED_PARAMETER.
- Edges during the E+1/E+2 pipeline are counted normally into the next block.
- Accumulator width is CW+AVG_LOG2; no overflow is possible.

Decomposition:
- Package pred_pkg:
  - state enum {IDLE, MEASURE};
  - width helper for W, CW and the accumulator;
  - the clamp function for the shift computation.
- Reuse the existing sync module for CDC.
- Sub-module pred_tune_avg: accumulator, index, divide, clamp and the 2-stage output pipeline.

Test Plan (defaults):
1. rst high 3 cycles with sgn toggling -> shift=1, lock=0, upd=0, half_period=0 throughout reset and until the first block completes.
2. Square wave, half-period 100, lead=20 -> upd pulses 2 cycles after the 5th detected edge; half_period=100, shift=80, lock=1; further upd every 4 edges.
3. Half-period 100 with lead=120 -> shift=1. Half-period 400 with lead=10 -> shift=255.
4. After lock, hold sgn static 1100 cycles -> lock falls when cnt reaches 1023, shift stays 80; resume toggling at half-period 100 -> relock and upd after 5 edges.
5. Locked at 100, inject a 2-cycle glitch pulse -> lock=0, shift holds 80, no upd; clean edges afterwards -> relock with the same values.
6. Half-periods 99,101,99,101 -> half_period=100, shift=80. Repeat with en dropped mid-block -> IDLE, no upd; re-enable -> fresh block starts at the next edge.
